// File: rtl/entry_sequencer_if.sv
// entry_sequencer bus: keypad strobes in, lock core
// drive out, status back to the panel.
interface entry_sequencer_if;
  logic [3:0] Key;
  logic       KeyValid;
  logic       KeyClear;
  logic       KeyEnter;
  logic       ModeSel;
  logic       LockErr;
  logic       LockUnlock;
  logic [3:0] Code;
  logic       Mode;
  logic       StepEn;
  logic       LockRst;
  logic [2:0] Count;
  logic       Busy;
  logic       Locked;
  logic       Pass;
  logic       Fail;
  logic       Timeout;

  modport master (
    output Key, KeyValid, KeyClear, KeyEnter,
    output ModeSel, LockErr, LockUnlock,
    input  Code, Mode, StepEn, LockRst, Count,
    input  Busy, Locked, Pass, Fail, Timeout
  );

  modport slave (
    input  Key, KeyValid, KeyClear, KeyEnter,
    input  ModeSel, LockErr, LockUnlock,
    output Code, Mode, StepEn, LockRst, Count,
    output Busy, Locked, Pass, Fail, Timeout
  );
endinterface

// File: rtl/entry_sequencer.sv
// entry_sequencer: buffers four keypad digits and
// replays them into the serial lock core on Enter.
module entry_sequencer #(
  parameter int TIMEOUT = 1000,
  parameter int LOCKOUT = 500
) (
  input logic CLK,
  input logic RST,
  entry_sequencer_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW = $clog2(LOCKOUT) + 1;
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCKOUT - 1);
  localparam logic [TW-1:0] T_ONE = 1;
  localparam logic [LW-1:0] L_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_KICK,
    S_MODE,
    S_SEND,
    S_CHECK,
    S_LOCKOUT
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    dig_q [4];
  logic [3:0]    dig_d [4];
  logic [2:0]    count_q, count_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [1:0]    idx_q, idx_d;
  logic          mode_q, mode_d;
  logic [3:0]    code_q, code_d;
  logic          step_q, step_d;
  logic          lrst_q, lrst_d;
  logic          clr;
  logic          pass_c, fail_c, tmo_c;
  logic          unlock_ok;

  assign unlock_ok = bus.LockUnlock & ~bus.LockErr;

  // next state, buffer updates and result pulses
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    count_d = count_q;
    idle_d  = idle_q;
    lock_d  = lock_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    clr     = 1'b0;
    pass_c  = 1'b0;
    fail_c  = 1'b0;
    tmo_c   = 1'b0;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (bus.KeyClear) begin
          clr     = 1'b1;
          idle_d  = '0;
          state_d = S_IDLE;
        end else if (bus.KeyEnter) begin
          idle_d = '0;
          if (count_q == 3'd4) begin
            mode_d  = bus.ModeSel;
            state_d = S_KICK;
          end else begin
            fail_c  = 1'b1;
            clr     = 1'b1;
            state_d = S_IDLE;
          end
        end else if (bus.KeyValid) begin
          idle_d  = '0;
          state_d = S_COLLECT;
          if (count_q != 3'd4) begin
            dig_d[count_q[1:0]] = bus.Key;
            count_d = count_q + 3'd1;
          end
        end else if (state_q == S_COLLECT) begin
          if (idle_q >= IDLE_MAX) begin
            tmo_c   = 1'b1;
            clr     = 1'b1;
            idle_d  = '0;
            state_d = S_IDLE;
          end else begin
            idle_d = idle_q + T_ONE;
          end
        end
      end
      S_KICK: state_d = S_MODE;
      S_MODE: begin
        idx_d   = 2'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (idx_q == 2'd3) state_d = S_CHECK;
        else idx_d = idx_q + 2'd1;
      end
      S_CHECK: begin
        clr = 1'b1;
        if (mode_q && !unlock_ok) begin
          fail_c  = 1'b1;
          lock_d  = '0;
          state_d = S_LOCKOUT;
        end else begin
          pass_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (lock_q >= LOCK_MAX) state_d = S_IDLE;
        else lock_d = lock_q + L_ONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      dig_d   = '{default: '0};
      count_d = '0;
    end
    step_d = (state_d == S_MODE) || (state_d == S_SEND);
    lrst_d = (state_d == S_KICK);
    code_d = (state_d == S_SEND) ? dig_d[idx_d] : dig_d[0];
  end

  // state and registered lock-core drive
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      dig_q   <= '{default: '0};
      count_q <= '0;
      idle_q  <= '0;
      lock_q  <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      code_q  <= '0;
      step_q  <= 1'b0;
      lrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      count_q <= count_d;
      idle_q  <= idle_d;
      lock_q  <= lock_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      code_q  <= code_d;
      step_q  <= step_d;
      lrst_q  <= lrst_d;
    end
  end

  assign bus.Code    = code_q;
  assign bus.Mode    = mode_q;
  assign bus.StepEn  = step_q;
  assign bus.LockRst = lrst_q;
  assign bus.Count   = count_q;
  assign bus.Busy    = !(state_q inside {S_IDLE, S_COLLECT});
  assign bus.Locked  = (state_q == S_LOCKOUT);
  assign bus.Pass    = pass_c & RST;
  assign bus.Fail    = fail_c & RST;
  assign bus.Timeout = tmo_c & RST;

endmodule

// File: tb/tb_entry_sequencer.sv
// tb_entry_sequencer: directed and random keypad traffic
// against a transaction-level model and a lock core stub.
module tb_entry_sequencer;
  localparam int TIMEOUT = 1000;
  localparam int LOCKOUT = 500;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  entry_sequencer_if bus ();

  entry_sequencer #(
    .TIMEOUT(TIMEOUT),
    .LOCKOUT(LOCKOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  logic [14:0] outs;
  assign outs = {bus.Code, bus.Mode, bus.StepEn,
                 bus.LockRst, bus.Count, bus.Busy,
                 bus.Locked, bus.Pass, bus.Fail,
                 bus.Timeout};

  // lock core stub: init -> set/val phase -> 4 digits
  logic [3:0] core_pw [4] = '{4'd0, 4'd1, 4'd0, 4'd3};
  logic [3:0] core_new [4] = '{default: 4'd0};
  int   core_ph = 3;
  int   core_i = 0;
  logic core_ok = 1'b0;
  logic core_unl = 1'b0;
  logic core_err = 1'b0;
  bit   err_inj = 1'b0;

  assign bus.LockUnlock = core_unl;
  assign bus.LockErr = core_err | err_inj;

  always @(posedge CLK) begin
    if (bus.LockRst) begin
      core_ph  <= 0;
      core_unl <= 1'b0;
      core_err <= 1'b0;
    end else if (bus.StepEn) begin
      if (core_ph == 0) begin
        core_ph <= bus.Mode ? 2 : 1;
        core_i  <= 0;
        core_ok <= 1'b1;
      end else if (core_ph != 3) begin
        if (core_ph == 1) core_new[core_i] <= bus.Code;
        core_ok <= core_ok && (bus.Code == core_pw[core_i]);
        core_i  <= core_i + 1;
        if (core_i == 3) begin
          core_ph <= 3;
          if (core_ph == 1) begin
            for (int k = 0; k < 3; k++)
              core_pw[k] <= core_new[k];
            core_pw[3] <= bus.Code;
          end else begin
            core_unl <= core_ok && (bus.Code == core_pw[3]);
            core_err <= !(core_ok && (bus.Code == core_pw[3]));
          end
        end
      end
    end
  end

  // reference model: buffer queue, pass timeline,
  // lockout and idle countdowns
  int q[$];
  int snap [4];
  int m_pw [4] = '{0, 1, 0, 3};
  int cyc = 0;
  int lock_rem = 0;
  int idle = 0;
  bit m_mode = 1'b0;

  initial begin
    logic [14:0] exp;
    int   e_code;
    bit   e_step, e_lrst, e_busy, e_lock;
    bit   ep, ef, et, ok;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        q.delete();
        cyc = 0;
        lock_rem = 0;
        idle = 0;
        m_mode = 1'b0;
        chk("reset_outs", 32'(outs), 32'd0);
        continue;
      end
      if (cyc >= 3 && cyc <= 6) e_code = snap[cyc-3];
      else e_code = (q.size() > 0) ? q[0] : 0;
      e_step = (cyc >= 2 && cyc <= 6);
      e_lrst = (cyc == 1);
      e_busy = (cyc > 0) || (lock_rem > 0);
      e_lock = (lock_rem > 0);
      exp = {4'(e_code), m_mode, e_step, e_lrst,
             3'(q.size()), e_busy, e_lock, 3'b000};
      ep = 0; ef = 0; et = 0;
      if (cyc > 0) begin
        if (cyc == 7) begin
          ok = 1;
          if (m_mode) begin
            for (int k = 0; k < 4; k++)
              if (snap[k] != m_pw[k]) ok = 0;
            if (err_inj) ok = 0;
          end else begin
            m_pw = snap;
          end
          ep = ok;
          ef = !ok;
          q.delete();
          cyc = 0;
          if (!ok) lock_rem = LOCKOUT;
        end else begin
          cyc++;
        end
      end else if (lock_rem > 0) begin
        lock_rem--;
      end else if (bus.KeyClear) begin
        q.delete();
        idle = 0;
      end else if (bus.KeyEnter) begin
        idle = 0;
        if (q.size() == 4) begin
          for (int k = 0; k < 4; k++) snap[k] = q[k];
          m_mode = bus.ModeSel;
          cyc = 1;
        end else begin
          ef = 1;
          q.delete();
        end
      end else if (bus.KeyValid) begin
        idle = 0;
        if (q.size() < 4) q.push_back(int'(bus.Key));
      end else if (q.size() > 0) begin
        if (idle == TIMEOUT - 1) begin
          et = 1;
          q.delete();
          idle = 0;
        end else begin
          idle++;
        end
      end
      exp[2:0] = {ep, ef, et};
      chk("cycle", 32'(outs), 32'(exp));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.Key = d;
    bus.KeyValid = 1'b1;
    tick();
    bus.KeyValid = 1'b0;
  endtask

  task automatic enter(input bit ms);
    bus.ModeSel = ms;
    bus.KeyEnter = 1'b1;
    tick();
    bus.KeyEnter = 1'b0;
  endtask

  task automatic press4(input logic [3:0] a, b, c, d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic run_pass(input bit ms,
                          input logic [3:0] a, b, c, d,
                          input bit ok);
    logic [3:0] dg [4];
    dg = '{a, b, c, d};
    enter(ms);
    @(negedge CLK);
    chk("kick_lrst", 32'({bus.LockRst, bus.StepEn}), 32'b10);
    @(negedge CLK);
    chk("mode_step", 32'({bus.StepEn, bus.Mode}), 32'({1'b1, ms}));
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("send_code", 32'({bus.StepEn, bus.Code}),
          32'({1'b1, dg[i]}));
    end
    @(negedge CLK);
    chk("check_res", 32'({bus.Pass, bus.Fail, bus.StepEn}),
        32'({ok, !ok, 1'b0}));
    tick();
  endtask

  initial begin
    int nlock;
    int r;
    int guard;
    bus.Key = '0;
    bus.KeyValid = 1'b0;
    bus.KeyClear = 1'b0;
    bus.KeyEnter = 1'b0;
    bus.ModeSel = 1'b0;
    repeat (3) tick();
    chk("reset_state", 32'(outs), 32'd0);
    RST = 1'b1;
    tick();
    chk("post_reset", 32'({bus.Count, bus.Busy}), 32'd0);

    // default core password 0,1,0,3
    press4(0, 1, 0, 3);
    run_pass(1'b1, 0, 1, 0, 3, 1'b1);
    chk("no_lock", 32'(bus.Locked), 32'd0);

    // set 1234 then validate it
    press4(1, 2, 3, 4);
    run_pass(1'b0, 1, 2, 3, 4, 1'b1);
    repeat (3) tick();
    press4(1, 2, 3, 4);
    run_pass(1'b1, 1, 2, 3, 4, 1'b1);
    chk("core_unlock", 32'(bus.LockUnlock), 32'd1);

    // wrong code -> lockout, key ignored inside it
    press4(9, 9, 9, 9);
    run_pass(1'b1, 9, 9, 9, 9, 1'b0);
    nlock = 0;
    for (int i = 0; i < 510; i++) begin
      bus.Key = 4'd7;
      bus.KeyValid = (i == 100);
      @(negedge CLK);
      if (bus.Locked) nlock++;
      tick();
    end
    bus.KeyValid = 1'b0;
    chk("lockout_len", 32'(nlock), 32'd500);
    chk("lockout_cnt", 32'(bus.Count), 32'd0);

    // short entry fails at once
    press(5);
    press(6);
    bus.KeyEnter = 1'b1;
    @(negedge CLK);
    chk("short_fail", 32'({bus.Fail, bus.Count}), 32'({1'b1, 3'd2}));
    tick();
    bus.KeyEnter = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("short_quiet",
          32'({bus.LockRst, bus.StepEn, bus.Count}), 32'd0);
    end
    tick();

    // fifth digit dropped
    press4(1, 2, 3, 4);
    press(5);
    chk("five_cnt", 32'(bus.Count), 32'd4);
    run_pass(1'b0, 1, 2, 3, 4, 1'b1);

    // clear beats a coincident digit
    press(7);
    bus.Key = 4'd8;
    bus.KeyValid = 1'b1;
    bus.KeyClear = 1'b1;
    tick();
    bus.KeyValid = 1'b0;
    bus.KeyClear = 1'b0;
    @(negedge CLK);
    chk("valid_clear", 32'(bus.Count), 32'd0);
    tick();

    // idle timeout after one key
    press(3);
    repeat (998) @(negedge CLK);
    @(negedge CLK);
    chk("pre_timeout", 32'({bus.Timeout, bus.Count}), 32'd1);
    @(negedge CLK);
    chk("timeout", 32'({bus.Timeout, bus.Count}),
        32'({1'b1, 3'd1}));
    tick();
    chk("timeout_cnt", 32'(bus.Count), 32'd0);

    // async reset during SEND cycle 2
    press4(1, 2, 3, 4);
    enter(1'b1);
    repeat (3) tick();
    chk("pre_rst_step", 32'(bus.StepEn), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst", 32'(outs), 32'd0);
    @(negedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    tick();
    press4(1, 2, 3, 4);
    run_pass(1'b1, 1, 2, 3, 4, 1'b1);

    // random traffic with periodic well-formed entries
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 150) begin
        guard = 0;
        while (bus.Busy && guard < 700) begin
          tick();
          guard++;
        end
        if (guard >= 700) chk("busy_bound", 32'd1, 32'd0);
        bus.KeyClear = 1'b1;
        tick();
        bus.KeyClear = 1'b0;
        press4(4'(m_pw[0]), 4'(m_pw[1]),
               4'(m_pw[2]), 4'(m_pw[3]));
        err_inj = ($urandom_range(0, 3) == 0);
        enter(1'b1);
        repeat (10) tick();
        err_inj = 1'b0;
      end
      r = int'($urandom_range(0, 99));
      bus.Key = 4'($urandom_range(0, 9));
      bus.ModeSel = ($urandom_range(0, 3) != 0);
      bus.KeyClear = (r < 2);
      bus.KeyEnter = (r >= 2 && r < 6);
      bus.KeyValid = (r >= 4 && r < 45);
      tick();
    end
    bus.KeyClear = 1'b0;
    bus.KeyEnter = 1'b0;
    bus.KeyValid = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
